// File: rtl/psram_bridge_pkg.sv
// Shared constants and FSM state type for the PSRAM UART command bridge.
package psram_bridge_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h3F;
   localparam logic [7:0] RSP_BUSY = 8'h42;
   localparam logic [7:0] RSP_TMO  = 8'h54;

   localparam logic [1:0] RW_IDLE  = 2'd0;
   localparam logic [1:0] RW_WRITE = 2'd1;
   localparam logic [1:0] RW_READ  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT_END,
      ST_RESP_HI,
      ST_RESP_LO
   } state_e;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/psram_uart_bridge_if.sv
// UART byte streams plus PSRAM command/response signals seen by the bridge.
interface psram_uart_bridge_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        qpi_on;
   logic        endcommand;
   logic [15:0] data_out;
   logic [22:0] address;
   logic [1:0]  read_write;
   logic        quad_start;
   logic [15:0] data_in;

   modport master (
      input  rx_data, rx_valid, tx_ready, qpi_on, endcommand, data_out,
      output tx_data, tx_valid, address, read_write, quad_start, data_in
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, qpi_on, endcommand, data_out,
      input  tx_data, tx_valid, address, read_write, quad_start, data_in
   );

endinterface

// File: rtl/psram_bridge_watchdog.sv
// Inter-byte gap counter; expired holds once TIMEOUT_CYCLES idle cycles have elapsed.
module psram_bridge_watchdog #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_400_000
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [23:0] count_q;
   logic [23:0] count_d;

   assign expired = (count_q == TIMEOUT_CYCLES);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 24'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/psram_uart_bridge.sv
// Assembles UART frames into PSRAM read/write commands and returns the response bytes.
// Optional frame timeout is enabled by defining PSRAM_BRIDGE_TIMEOUT_EN.
module psram_uart_bridge
   import psram_bridge_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_400_000,
   parameter int unsigned GUARD_CYCLES   = 3
) (
   input  logic                       mem_clk,
   input  logic                       rst,
   psram_uart_bridge_if.master        bus,
   output logic                       busy,
   output logic                       overrun
);

   // GUARD always lasts at least one cycle, even if GUARD_CYCLES is 0.
   localparam logic [7:0] GUARD_LAST = (GUARD_CYCLES > 1) ? 8'(GUARD_CYCLES - 1) : 8'd0;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        is_read_q, is_read_d;
   logic [22:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [7:0]  rd_lo_q, rd_lo_d;
   logic [7:0]  guard_q, guard_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic [22:0] address_q, address_d;
   logic [1:0]  read_write_q, read_write_d;
   logic        quad_start_q, quad_start_d;
   logic [15:0] data_in_q, data_in_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;

   logic        accepting;
   logic        rx_accept;
   logic        wdg_expired;
   logic [22:0] addr_shift;
   logic [15:0] wdata_shift;

   assign accepting   = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign rx_accept   = bus.rx_valid && accepting;
   assign addr_shift  = {addr_q[14:0], bus.rx_data};
   assign wdata_shift = {wdata_q[7:0], bus.rx_data};

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
   logic wdg_enable;
   logic wdg_clear;

   assign wdg_enable = (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign wdg_clear  = rx_accept || !wdg_enable;

   psram_bridge_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (mem_clk),
      .srst    (rst),
      .clear   (wdg_clear),
      .enable  (wdg_enable),
      .expired (wdg_expired)
   );
`else
   logic unused_timeout;

   assign wdg_expired    = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      is_read_d    = is_read_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_lo_d      = rd_lo_q;
      guard_d      = guard_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      address_d    = address_q;
      read_write_d = read_write_q;
      quad_start_d = 1'b0;
      data_in_d    = data_in_q;
      overrun_d    = overrun_q || (bus.rx_valid && !accepting);

      case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid) begin
               if (is_opcode(bus.rx_data) && bus.qpi_on) begin
                  is_read_d = (bus.rx_data == OP_READ);
                  idx_d     = 2'd0;
                  state_d   = ST_ADDR;
               end else begin
                  tx_data_d  = is_opcode(bus.rx_data) ? RSP_BUSY : RSP_ERR;
                  tx_valid_d = 1'b1;
                  state_d    = ST_RESP_LO;
               end
            end
         end
         ST_ADDR: begin
            if (bus.rx_valid) begin
               addr_d = addr_shift;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd2) begin
                  idx_d = 2'd0;
                  if (is_read_q) begin
                     address_d    = addr_shift;
                     read_write_d = RW_READ;
                     quad_start_d = 1'b1;
                     state_d      = ST_ISSUE;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end else if (wdg_expired) begin
               tx_data_d  = RSP_TMO;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP_LO;
            end
         end
         ST_DATA: begin
            if (bus.rx_valid) begin
               wdata_d = wdata_shift;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd1) begin
                  address_d    = addr_q;
                  data_in_d    = wdata_shift;
                  read_write_d = RW_WRITE;
                  quad_start_d = 1'b1;
                  state_d      = ST_ISSUE;
               end
            end else if (wdg_expired) begin
               tx_data_d  = RSP_TMO;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP_LO;
            end
         end
         ST_ISSUE: begin
            guard_d = 8'd0;
            state_d = ST_GUARD;
         end
         ST_GUARD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = ST_WAIT_END;
            end else begin
               guard_d = guard_q + 8'd1;
            end
         end
         ST_WAIT_END: begin
            if (bus.endcommand) begin
               read_write_d = RW_IDLE;
               tx_valid_d   = 1'b1;
               if (is_read_q) begin
                  tx_data_d = bus.data_out[15:8];
                  rd_lo_d   = bus.data_out[7:0];
                  state_d   = ST_RESP_HI;
               end else begin
                  tx_data_d = RSP_ACK;
                  state_d   = ST_RESP_LO;
               end
            end
         end
         ST_RESP_HI: begin
            if (bus.tx_ready) begin
               tx_data_d = rd_lo_q;
               state_d   = ST_RESP_LO;
            end
         end
         ST_RESP_LO: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         is_read_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_lo_q      <= '0;
         guard_q      <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         address_q    <= '0;
         read_write_q <= RW_IDLE;
         quad_start_q <= 1'b0;
         data_in_q    <= '0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         is_read_q    <= is_read_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rd_lo_q      <= rd_lo_d;
         guard_q      <= guard_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         address_q    <= address_d;
         read_write_q <= read_write_d;
         quad_start_q <= quad_start_d;
         data_in_q    <= data_in_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_valid   = tx_valid_q;
   assign bus.address    = address_q;
   assign bus.read_write = read_write_q;
   assign bus.quad_start = quad_start_q;
   assign bus.data_in    = data_in_q;
   assign busy           = busy_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_psram_uart_bridge.sv
// Self-checking bench: frame-level reference model, PSRAM responder and UART sink.
module tb_psram_uart_bridge;

   localparam int GUARD = 3;

   logic mem_clk = 1'b0;
   logic rst     = 1'b1;
   logic busy;
   logic overrun;

   psram_uart_bridge_if bus();

   psram_uart_bridge #(
      .TIMEOUT_CYCLES (24'd100),
      .GUARD_CYCLES   (GUARD)
   ) dut (
      .mem_clk (mem_clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 mem_clk = ~mem_clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          qs_count = 0;
   logic [22:0] qs_addr;
   logic [1:0]  qs_rw;
   logic [15:0] qs_data;
   logic [15:0] rd_word;

   // Count every cycle with quad_start high and record the command it carried.
   initial begin
      forever begin
         @(negedge mem_clk);
         if (bus.quad_start === 1'b1) begin
            qs_count++;
            qs_addr = bus.address;
            qs_rw   = bus.read_write;
            qs_data = bus.data_in;
         end
      end
   end

   // PSRAM stand-in: a decoy endcommand inside the guard window, then the real one.
   initial begin
      int k;
      bus.endcommand = 1'b0;
      bus.data_out   = 16'h0000;
      forever begin
         @(negedge mem_clk);
         if (bus.quad_start === 1'b1) begin
            k = 2 + int'($urandom_range(0, 3));
            @(posedge mem_clk); #1;
            bus.endcommand = 1'b1;
            bus.data_out   = 16'($urandom);
            @(posedge mem_clk); #1;
            bus.endcommand = 1'b0;
            repeat (k) begin
               @(posedge mem_clk); #1;
            end
            bus.endcommand = 1'b1;
            bus.data_out   = rd_word;
            @(posedge mem_clk); #1;
            bus.endcommand = 1'b0;
            bus.data_out   = 16'($urandom);
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timed out");
   end

   task automatic tick();
      @(posedge mem_clk); #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_data"},    32'(bus.tx_data), 32'h0);
      check({tag, "_tx_valid"},   32'(bus.tx_valid), 32'h0);
      check({tag, "_address"},    32'(bus.address), 32'h0);
      check({tag, "_read_write"}, 32'(bus.read_write), 32'h0);
      check({tag, "_quad_start"}, 32'(bus.quad_start), 32'h0);
      check({tag, "_data_in"},    32'(bus.data_in), 32'h0);
      check({tag, "_busy"},       32'(busy), 32'h0);
      check({tag, "_overrun"},    32'(overrun), 32'h0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   // Waits (bounded) for a response byte, holds tx_ready low for 'stall' cycles, then accepts.
   task automatic get_byte(output logic [7:0] b, input int stall);
      int n = 0;
      while (bus.tx_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("tx_valid_seen", 32'(bus.tx_valid), 32'h1);
      b = bus.tx_data;
      repeat (stall) begin
         tick();
         check("tx_hold_valid", 32'(bus.tx_valid), 32'h1);
         check("tx_hold_data", 32'(bus.tx_data), 32'(b));
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [23:0] a, input logic [15:0] wd,
                            input logic qpi, input int stall, input logic [15:0] rword,
                            input bit inject_overrun);
      logic [7:0] exp_rsp[$];
      logic [7:0] b;
      bit         issues;
      bit         is_w;
      int         qs0;

      is_w   = (op == 8'h57);
      issues = ((op == 8'h57) || (op == 8'h52)) && qpi;
      if (issues) begin
         if (is_w) exp_rsp.push_back(8'h4B);
         else begin
            exp_rsp.push_back(rword[15:8]);
            exp_rsp.push_back(rword[7:0]);
         end
      end else if ((op == 8'h57) || (op == 8'h52)) begin
         exp_rsp.push_back(8'h42);
      end else begin
         exp_rsp.push_back(8'h3F);
      end

      rd_word    = rword;
      bus.qpi_on = qpi;
      qs0        = qs_count;

      send_byte(op);
      if (issues) begin
         gap(); send_byte(a[23:16]);
         gap(); send_byte(a[15:8]);
         gap(); send_byte(a[7:0]);
         if (is_w) begin
            gap(); send_byte(wd[15:8]);
            gap(); send_byte(wd[7:0]);
         end
         check("qs_latency", 32'(bus.quad_start), 32'h1);
         check("qs_address", 32'(bus.address), 32'(a[22:0]));
         check("qs_rw", 32'(bus.read_write), is_w ? 32'h1 : 32'h2);
         if (inject_overrun) begin
            repeat (GUARD + 1) tick();
            send_byte(8'($urandom));
         end
      end

      foreach (exp_rsp[i]) begin
         get_byte(b, stall);
         check("rsp_byte", 32'(b), 32'(exp_rsp[i]));
      end
      check("tx_valid_drop", 32'(bus.tx_valid), 32'h0);
      check("busy_after", 32'(busy), 32'h0);
      check("rw_after", 32'(bus.read_write), 32'h0);
      check("qs_pulses", 32'(qs_count - qs0), issues ? 32'h1 : 32'h0);
      if (issues) begin
         check("cmd_addr", 32'(qs_addr), 32'(a[22:0]));
         check("cmd_rw", 32'(qs_rw), is_w ? 32'h1 : 32'h2);
         if (is_w) check("cmd_data", 32'(qs_data), 32'(wd));
      end
      $display("frame op=%02h addr=%06h wd=%04h qpi=%0d rsp_bytes=%0d", op, a, wd, qpi, exp_rsp.size());
   endtask

   initial begin
      logic [7:0] op;
      int         kind;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
      bus.qpi_on   = 1'b1;
      rd_word      = 16'h0000;
      rst          = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      run_frame(8'h57, 24'h001234, 16'hABCD, 1'b1, 0, 16'h0000, 1'b0);
      run_frame(8'h52, 24'h7F0001, 16'h0000, 1'b1, 10, 16'hBEEF, 1'b0);
      run_frame(8'h41, 24'h000000, 16'h0000, 1'b1, 0, 16'h0000, 1'b0);
      run_frame(8'h52, 24'h000000, 16'h0000, 1'b0, 2, 16'h0000, 1'b0);

      check("overrun_clear", 32'(overrun), 32'h0);
      run_frame(8'h52, 24'h123456, 16'h0000, 1'b1, 1, 16'h5AA5, 1'b1);
      check("overrun_set", 32'(overrun), 32'h1);
      run_frame(8'h57, 24'hFFFFFF, 16'h0F0F, 1'b1, 0, 16'h0000, 1'b0);
      check("overrun_sticky", 32'(overrun), 32'h1);

      bus.qpi_on = 1'b1;
      send_byte(8'h57);
      send_byte(8'h00);
      rst = 1'b1;
      tick();
      check_reset_outputs("midaddr_rst");
      rst = 1'b0;
      tick();
      run_frame(8'h57, 24'h00ABCD, 16'h1357, 1'b1, 0, 16'h0000, 1'b0);

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            op = 8'($urandom);
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
            run_frame(op, 24'h0, 16'h0, 1'($urandom), 0, 16'h0, 1'b0);
         end else if (kind == 1) begin
            run_frame(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52, 24'h0, 16'h0, 1'b0, 0, 16'h0, 1'b0);
         end else begin
            run_frame(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52, 24'($urandom), 16'($urandom),
                      1'b1, int'($urandom_range(0, 3)), 16'($urandom), 1'b0);
         end
      end

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
      begin
         logic [7:0] b;
         logic       early;
         int         qs0;
         bus.qpi_on = 1'b1;
         qs0   = qs_count;
         early = 1'b0;
         send_byte(8'h57);
         send_byte(8'h00);
         repeat (95) begin
            tick();
            if (bus.tx_valid !== 1'b0) early = 1'b1;
         end
         check("tmo_not_early", 32'(early), 32'h0);
         get_byte(b, 0);
         check("tmo_rsp", 32'(b), 32'h54);
         check("tmo_busy", 32'(busy), 32'h0);
         check("tmo_no_qs", 32'(qs_count - qs0), 32'h0);
         $display("frame timeout rsp=%02h", b);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
